// File: rtl/tdm_demux4_if.sv
// Bundle of the serial TDM link input and the rebuilt parallel frame output.
// TDM_DEMUX_PARITY_EN adds the parity_err signal to the bundle.
interface tdm_demux4_if;
  logic       en;
  logic       din;
  logic       frame_sync;
  logic [3:0] d;
  logic       frame_valid;
  logic       sync_lost;
`ifdef TDM_DEMUX_PARITY_EN
  logic       parity_err;

  modport master (output en, din, frame_sync,
                  input  d, frame_valid, sync_lost, parity_err);
  modport slave  (input  en, din, frame_sync,
                  output d, frame_valid, sync_lost, parity_err);
`else
  modport master (output en, din, frame_sync,
                  input  d, frame_valid, sync_lost);
  modport slave  (input  en, din, frame_sync,
                  output d, frame_valid, sync_lost);
`endif
endinterface

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer with HUNT/LOCKED frame alignment and flywheel miss counting.
// Defining TDM_DEMUX_PARITY_EN adds a fifth even-parity slot and the parity_err pulse.
module tdm_demux4 #(
  parameter int MISS_LIMIT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  tdm_demux4_if.slave   bus
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int N = 5;
`else
  localparam int N = 4;
`endif
  localparam int COLW = N - 1;
  localparam logic [2:0] LAST_SLOT = 3'(N - 1);
  localparam logic [2:0] MISS_LIM  = 3'(MISS_LIMIT);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_cnt, w_cnt_nxt;
  logic [2:0]      r_miss, w_miss_nxt;
  logic [2:0]      w_miss_inc;
  logic [COLW-1:0] r_col, w_col_nxt;
  logic [3:0]      r_d, w_d_nxt;
  logic            r_fv, w_fv_nxt;
`ifdef TDM_DEMUX_PARITY_EN
  logic            r_perr, w_perr_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_cnt   <= '0;
      r_miss  <= '0;
      r_col   <= '0;
      r_d     <= '0;
      r_fv    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_miss  <= w_miss_nxt;
      r_col   <= w_col_nxt;
      r_d     <= w_d_nxt;
      r_fv    <= w_fv_nxt;
`ifdef TDM_DEMUX_PARITY_EN
      r_perr  <= w_perr_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_miss_nxt  = r_miss;
    w_col_nxt   = r_col;
    w_d_nxt     = r_d;
    w_fv_nxt    = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    w_perr_nxt  = 1'b0;
`endif
    w_miss_inc  = r_miss + 3'd1;

    if (bus.en) begin
      case (r_state)
        HUNT: begin
          if (bus.frame_sync) begin
            w_state_nxt  = LOCKED;
            w_col_nxt[0] = bus.din;
            w_cnt_nxt    = 3'd1;
            w_miss_nxt   = '0;
          end
        end
        LOCKED: begin
          if (r_cnt == 3'd0 && bus.frame_sync) begin
            w_col_nxt[0] = bus.din;
            w_cnt_nxt    = 3'd1;
            w_miss_nxt   = '0;
          end else if (r_cnt == 3'd0 || bus.frame_sync) begin
            // Missing or misplaced sync: reaching the limit wins over taking the slot.
            if (w_miss_inc >= MISS_LIM) begin
              w_state_nxt = HUNT;
              w_cnt_nxt   = '0;
              w_miss_nxt  = '0;
            end else begin
              w_col_nxt[0] = bus.din;
              w_cnt_nxt    = 3'd1;
              w_miss_nxt   = w_miss_inc;
            end
          end else if (r_cnt == LAST_SLOT) begin
            w_cnt_nxt = '0;
            w_fv_nxt  = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
            w_d_nxt    = r_col[3:0];
            w_perr_nxt = ^{bus.din, r_col};
`else
            w_d_nxt    = {bus.din, r_col[2:0]};
`endif
          end else begin
            for (int k = 1; k < COLW; k++) begin
              if (r_cnt == 3'(k)) w_col_nxt[k] = bus.din;
            end
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  assign bus.d           = r_d;
  assign bus.frame_valid = r_fv;
  assign bus.sync_lost   = (r_state == HUNT);
`ifdef TDM_DEMUX_PARITY_EN
  assign bus.parity_err  = r_perr;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: lock, gated enable, flywheel, misalignment, async reset, parity.
module tb_tdm_demux4;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   fv_cnt;

  tdm_demux4_if bus();

  tdm_demux4 #(.MISS_LIMIT(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.frame_valid === 1'b1) fv_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input logic e, input logic fs, input logic b);
    bus.en = e;
    bus.frame_sync = fs;
    bus.din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [3:0] v, input logic s0);
    step(1'b1, s0, v[0]);
    step(1'b1, 1'b0, v[1]);
    step(1'b1, 1'b0, v[2]);
    step(1'b1, 1'b0, v[3]);
`ifdef TDM_DEMUX_PARITY_EN
    step(1'b1, 1'b0, ^v);
`endif
  endtask

  initial begin
    n_chk = 0; n_pass = 0; fv_cnt = 0;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.frame_sync = 1'b0; bus.din = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_d", 32'(bus.d), 32'h0);
    chk("rst_sync_lost", 32'(bus.sync_lost), 32'h1);
    chk("rst_fv", 32'(bus.frame_valid), 32'h0);
`ifdef TDM_DEMUX_PARITY_EN
    chk("rst_perr", 32'(bus.parity_err), 32'h0);
`endif
    rst_n = 1'b1;

    // lock on first frame 1,0,1,1
    step(1'b1, 1'b1, 1'b1);
    chk("lock_sync_lost", 32'(bus.sync_lost), 32'h0);
    chk("lock_fv_early", 32'(bus.frame_valid), 32'h0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
`ifdef TDM_DEMUX_PARITY_EN
    step(1'b1, 1'b0, 1'b1);
    chk("lock_perr", 32'(bus.parity_err), 32'h0);
`endif
    chk("lock_d", 32'(bus.d), 32'hD);
    chk("lock_fv", 32'(bus.frame_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    chk("lock_fv_off", 32'(bus.frame_valid), 32'h0);
    chk("lock_fv_cnt", 32'(fv_cnt), 32'd1);

    frame(4'b0110, 1'b1);
    chk("f2_d", 32'(bus.d), 32'h6);

    // gated enable between slots 1 and 2
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("gate_fv_low1", 32'(bus.frame_valid), 32'h0);
    step(1'b0, 1'b0, 1'b1);
    chk("gate_fv_low2", 32'(bus.frame_valid), 32'h0);
    chk("gate_d_hold", 32'(bus.d), 32'h6);
    step(1'b1, 1'b0, 1'b1);
    chk("gate_fv_pre", 32'(bus.frame_valid), 32'h0);
    step(1'b1, 1'b0, 1'b1);
`ifdef TDM_DEMUX_PARITY_EN
    step(1'b1, 1'b0, 1'b1);
`endif
    chk("gate_d", 32'(bus.d), 32'hD);
    chk("gate_fv", 32'(bus.frame_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    chk("gate_fv_cnt", 32'(fv_cnt), 32'd3);

    // flywheel: first miss tolerated, second drops to HUNT
    frame(4'b1010, 1'b0);
    chk("fly1_d", 32'(bus.d), 32'hA);
    chk("fly1_fv", 32'(bus.frame_valid), 32'h1);
    chk("fly1_sync_lost", 32'(bus.sync_lost), 32'h0);
    step(1'b1, 1'b0, 1'b1);
    chk("fly2_sync_lost", 32'(bus.sync_lost), 32'h1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
    step(1'b1, 1'b0, 1'b0);
`endif
    chk("fly2_fv", 32'(bus.frame_valid), 32'h0);
    chk("fly2_d", 32'(bus.d), 32'hA);
    step(1'b0, 1'b0, 1'b0);
    chk("fly2_fv_cnt", 32'(fv_cnt), 32'd4);

    // misalignment: sync at cnt=2 restarts frame 0,1,1,1
    frame(4'b0011, 1'b1);
    chk("mis_pre_d", 32'(bus.d), 32'h3);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("mis_sync_lost", 32'(bus.sync_lost), 32'h0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
`ifdef TDM_DEMUX_PARITY_EN
    step(1'b1, 1'b0, 1'b1);
`endif
    chk("mis_d", 32'(bus.d), 32'hE);
    chk("mis_fv", 32'(bus.frame_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    chk("mis_fv_cnt", 32'(fv_cnt), 32'd6);

    // async reset at slot 2
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_d", 32'(bus.d), 32'h0);
    chk("arst_sync_lost", 32'(bus.sync_lost), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    chk("arst_hunt", 32'(bus.sync_lost), 32'h1);
    chk("arst_fv_cnt", 32'(fv_cnt), 32'd6);
    frame(4'b1001, 1'b1);
    chk("arst_relock_d", 32'(bus.d), 32'h9);
    chk("arst_relock_fv", 32'(bus.frame_valid), 32'h1);

`ifdef TDM_DEMUX_PARITY_EN
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("par_d", 32'(bus.d), 32'hD);
    chk("par_fv", 32'(bus.frame_valid), 32'h1);
    chk("par_err", 32'(bus.parity_err), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    chk("par_err_off", 32'(bus.parity_err), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
